// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce; optional auto-repeat under KEYPAD_REPEAT_EN
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 8,
    parameter int REPEAT_DLY   = 25000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_detect,
    output logic       key_down
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_DONE  = DW'(DEBOUNCE_CNT);

    // Elaboration-time guard on parameter ranges
    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_DLY < 1) begin : g_param_check
        $error("keypad_scanner: SCAN_DIV>=4, DEBOUNCE_CNT>=1, REPEAT_DLY>=1 required");
    end

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        PRESSED   = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [3:0]      rows_meta, rows_s;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [1:0]      col_idx, col_idx_nx;
    logic [1:0]      key_row, key_row_nx;
    logic [1:0]      key_col, key_col_nx;
    logic [DW-1:0]   deb_cnt, deb_cnt_nx;
    logic [3:0]      key_code_nx;
    logic            key_detect_nx, key_down_nx;
    logic            act_hit;
    logic [1:0]      act_row;
    logic            row_level;

    // Two-flop synchroniser for the asynchronous row inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_meta <= 4'b1111;
            rows_s    <= 4'b1111;
        end else begin
            rows_meta <= row_n;
            rows_s    <= rows_meta;
        end
    end

    // Free-running scan tick divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    assign tick      = (tick_cnt == TICK_LAST);
    assign col_n     = ~(4'b0001 << col_idx);
    assign row_level = rows_s[key_row];

    // Lowest-index active row wins when several rows are low
    always_comb begin
        act_hit = 1'b0;
        act_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_s[i]) begin
                act_hit = 1'b1;
                act_row = 2'(i);
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DLY + 1);
    localparam logic [RW-1:0] REP_DONE = RW'(REPEAT_DLY);
    logic [RW-1:0] rep_cnt, rep_cnt_nx;

    // Repeat tick counter, only advanced while the key is confirmed held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt_nx;
        end
    end
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SCAN;
            col_idx    <= 2'd0;
            key_row    <= 2'd0;
            key_col    <= 2'd0;
            deb_cnt    <= '0;
            key_code   <= 4'd0;
            key_detect <= 1'b0;
            key_down   <= 1'b0;
        end else begin
            state      <= state_nx;
            col_idx    <= col_idx_nx;
            key_row    <= key_row_nx;
            key_col    <= key_col_nx;
            deb_cnt    <= deb_cnt_nx;
            key_code   <= key_code_nx;
            key_detect <= key_detect_nx;
            key_down   <= key_down_nx;
        end
    end

    // Next-state logic: scan, debounce press, hold, debounce release
    always_comb begin
        state_nx      = state;
        col_idx_nx    = col_idx;
        key_row_nx    = key_row;
        key_col_nx    = key_col;
        deb_cnt_nx    = deb_cnt;
        key_code_nx   = key_code;
        key_detect_nx = 1'b0;
        key_down_nx   = key_down;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_nx    = rep_cnt;
`endif
        if (tick) begin
            case (state)
                SCAN: begin
                    if (act_hit) begin
                        key_row_nx = act_row;
                        key_col_nx = col_idx;
                        deb_cnt_nx = '0;
                        state_nx   = DEB_PRESS;
                    end else begin
                        col_idx_nx = col_idx + 2'd1;
                    end
                end
                DEB_PRESS: begin
                    if (!row_level) begin
                        if (deb_cnt != DEB_DONE) begin
                            deb_cnt_nx = deb_cnt + 1'b1;
                        end
                        if (deb_cnt_nx == DEB_DONE) begin
                            state_nx      = PRESSED;
                            key_code_nx   = {key_row, key_col};
                            key_detect_nx = 1'b1;
                            key_down_nx   = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt_nx    = '0;
`endif
                        end
                    end else begin
                        state_nx   = SCAN;
                        col_idx_nx = col_idx + 2'd1;
                    end
                end
                PRESSED: begin
                    if (row_level) begin
                        deb_cnt_nx = '0;
                        state_nx   = DEB_REL;
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        if (rep_cnt + 1'b1 == REP_DONE) begin
                            key_detect_nx = 1'b1;
                            rep_cnt_nx    = '0;
                        end else begin
                            rep_cnt_nx = rep_cnt + 1'b1;
                        end
`endif
                    end
                end
                DEB_REL: begin
                    if (row_level) begin
                        if (deb_cnt != DEB_DONE) begin
                            deb_cnt_nx = deb_cnt + 1'b1;
                        end
                        if (deb_cnt_nx == DEB_DONE) begin
                            state_nx    = SCAN;
                            key_down_nx = 1'b0;
                            col_idx_nx  = col_idx + 2'd1;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt_nx  = '0;
`endif
                        end
                    end else begin
                        state_nx = PRESSED;
                    end
                end
                default: state_nx = SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed scoreboard bench for keypad_scanner
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 3;
    localparam int RD = 10;
`ifdef KEYPAD_REPEAT_EN
    localparam int HOLD2   = 8;
    localparam int NSTROBE = 4;
`else
    localparam int HOLD2   = 20;
    localparam int NSTROBE = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_detect;
    logic        key_down;
    logic [15:0] pressed = '0;
    logic        prev_det = 1'b0;

    int checks = 0;
    int failures = 0;
    int strobes = 0;
    int cyc = 0;
    int s0;
    logic [3:0] exp_q[$];
    int         stamp_q[$];

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB), .REPEAT_DLY(RD)) dut (
        .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
        .key_code(key_code), .key_detect(key_detect), .key_down(key_down)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Keypad model: pressed[r*4+c] connects row r to column c
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            row_n[r] = ~|(pressed[r*4 +: 4] & ~col_n);
        end
    end

    // Scoreboard monitor: each strobe pops one expected key code
    always @(negedge clk) begin
        logic [3:0] e;
        if (rst_n && key_detect) begin
            strobes++;
            stamp_q.push_back(cyc);
            checks++;
            assert (prev_det !== 1'b1) else begin
                failures++;
                $error("FAIL det_consecutive observed=1 expected=0");
            end
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL sb_unexpected observed code=%h expected no strobe", key_code);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                assert (key_code === e) else begin
                    failures++;
                    $error("FAIL sb_code observed=%h expected=%h", key_code, e);
                end
            end
        end
        prev_det <= key_detect;
    end

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n * SD) @(negedge clk);
    endtask

    task automatic wait_strobes(input string tag, input int n);
        int b = 0;
        while (strobes < n && b < 300) begin
            @(negedge clk);
            b++;
        end
        checks++;
        assert (strobes >= n) else begin
            failures++;
            $error("FAIL %s observed strobes=%0d expected>=%0d", tag, strobes, n);
        end
    endtask

    task automatic wait_down(input string tag, input logic v);
        int b = 0;
        while (key_down !== v && b < 300) begin
            @(negedge clk);
            b++;
        end
        chk4(tag, {3'b000, key_down}, {3'b000, v});
    endtask

    task automatic wait_col(input string tag, input logic [3:0] v);
        int b = 0;
        while (col_n !== v && b < 100) begin
            @(negedge clk);
            b++;
        end
        chk4(tag, col_n, v);
    endtask

    initial begin
        // 1: asynchronous reset mid-scan
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk4("rst_col_n", col_n, 4'b1110);
        chk4("rst_key_code", key_code, 4'b0000);
        chk4("rst_key_detect", {3'b000, key_detect}, 4'b0000);
        chk4("rst_key_down", {3'b000, key_down}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // 2: clean press row1/col2, hold, release
        s0 = strobes;
        exp_q.push_back(4'b0110);
        pressed[1*4+2] = 1'b1;
        wait_strobes("t2_strobe", s0 + 1);
        ticks(HOLD2);
        chk_int("t2_one_strobe", strobes, s0 + 1);
        chk4("t2_key_code", key_code, 4'b0110);
        chk4("t2_key_down", {3'b000, key_down}, 4'b0001);
        pressed = '0;
        wait_down("t2_release", 1'b0);
        chk4("t2_col_after_rel", col_n, 4'b0111);

        // 3: bounce on row0/col0 shorter than the debounce window
        s0 = strobes;
        wait_col("t3_col0", 4'b1110);
        pressed[0] = 1'b1;
        repeat (9) @(negedge clk);
        pressed = '0;
        ticks(6);
        chk_int("t3_no_strobe", strobes, s0);
        chk4("t3_code_kept", key_code, 4'b0110);
        chk4("t3_not_down", {3'b000, key_down}, 4'b0000);
        wait_col("t3_scan_resumes", 4'b1101);

        // 4: release glitch while held
        s0 = strobes;
        exp_q.push_back(4'b1001);
        pressed[2*4+1] = 1'b1;
        wait_strobes("t4_strobe", s0 + 1);
        ticks(2);
        pressed = '0;
        repeat (2 * SD) @(negedge clk);
        pressed[2*4+1] = 1'b1;
        ticks(4);
        chk4("t4_still_down", {3'b000, key_down}, 4'b0001);
        chk_int("t4_no_new_strobe", strobes, s0 + 1);
        pressed = '0;
        wait_down("t4_release", 1'b0);

        // 5: rows 0 and 3 in column 1 together
        s0 = strobes;
        exp_q.push_back(4'b0001);
        pressed[0*4+1] = 1'b1;
        pressed[3*4+1] = 1'b1;
        wait_strobes("t5_strobe", s0 + 1);
        ticks(2);
        chk4("t5_key_code", key_code, 4'b0001);
        chk_int("t5_one_strobe", strobes, s0 + 1);
        pressed = '0;
        wait_down("t5_release", 1'b0);

        // 6: long hold of row3/col3
        s0 = strobes;
        for (int i = 0; i < NSTROBE; i++) exp_q.push_back(4'b1111);
        pressed[3*4+3] = 1'b1;
        wait_strobes("t6_strobe", s0 + 1);
        ticks(35);
        pressed = '0;
        wait_down("t6_release", 1'b0);
        chk_int("t6_strobe_count", strobes, s0 + NSTROBE);
        chk4("t6_key_code", key_code, 4'b1111);
`ifdef KEYPAD_REPEAT_EN
        if (stamp_q.size() >= 4) begin
            for (int i = stamp_q.size() - 3; i < stamp_q.size(); i++) begin
                chk_int("t6_repeat_gap", stamp_q[i] - stamp_q[i-1], RD * SD);
            end
        end
`endif

        chk_int("sb_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
